// File: rtl/systolic_feeder.sv
// Skews A-column / B-row beats into a systolic array's west and north edges, then flushes.
// Optional stall counter port enabled by defining SYSTOLIC_FEEDER_STALL_CNT_EN.
module systolic_feeder #(
    parameter int unsigned N         = 32,
    parameter int unsigned DW        = 16,
    parameter int unsigned DRAIN_CYC = 3*N-2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0][DW-1:0] a_in,
    input  logic [N-1:0][DW-1:0] b_in,
    output logic [N-1:0][DW-1:0] A_west,
    output logic [N-1:0][DW-1:0] B_north,
    output logic                 busy,
    output logic                 done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [15:0]    r_k_len;
    logic [15:0]    r_beat_cnt;
    logic [CW-1:0]  r_drain_cnt;
    logic           w_accept;
    logic           w_last_beat;
    logic           w_start_acc;

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_beat_cnt == (r_k_len - 16'd1));
    assign w_start_acc = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (k_len != 16'd0) ? S_FEED : S_DRAIN;
            S_FEED:  if (w_accept && w_last_beat) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE:  busy     = 1'b0;
            S_FEED:  in_ready = 1'b1;
            S_DONE:  done     = 1'b1;
            default: ;
        endcase
    end

    // Tile length, beat and flush counters; drain count restarts on every DRAIN entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_k_len    <= k_len;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CW'(1);
            else                    r_drain_cnt <= '0;
        end
    end

    // Lane i delays by i+1 cycles; zero enters whenever no beat is accepted.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [i:0][DW-1:0] r_a_pipe;
        logic [i:0][DW-1:0] r_b_pipe;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_a_pipe <= '0;
                r_b_pipe <= '0;
            end else begin
                r_a_pipe[0] <= w_accept ? a_in[i] : '0;
                r_b_pipe[0] <= w_accept ? b_in[i] : '0;
                for (int s = 1; s <= i; s++) begin
                    r_a_pipe[s] <= r_a_pipe[s-1];
                    r_b_pipe[s] <= r_b_pipe[s-1];
                end
            end
        end

        assign A_west[i]  = r_a_pipe[i];
        assign B_north[i] = r_b_pipe[i];
    end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of FEED cycles with no offered beat.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_FEED) && !in_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the array dimension (lanes per side).
REQ-002 The block SHALL have parameter DW, default 16, giving the element width.
REQ-003 The block SHALL have parameter DRAIN_CYC, default 3*N-2, giving the flush length in cycles after the last beat.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1, a pulse that begins one tile feed.
REQ-007 The block SHALL have port k_len, input, 16, the number of k-beats in the tile, sampled on start.
REQ-008 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), a_in (input, [N][DW], one A column slice) and b_in (input, [N][DW], one B row slice) forming the beat handshake.
REQ-009 The block SHALL have ports A_west (output, [N][DW]) and B_north (output, [N][DW]), the skewed streams into the array's west and north edges.
REQ-010 The block SHALL have ports busy (output, 1), high when not IDLE, and done (output, 1), a one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have states IDLE, FEED, DRAIN and DONE.
REQ-012 IDLE: in_ready=0; start latches k_len; the FSM goes to FEED if k_len!=0, else to DRAIN.
REQ-013 FEED: in_ready=1; a beat is accepted when in_valid&&in_ready; beat_cnt increments per accepted beat; on the accepted beat where beat_cnt==k_len-1 the FSM goes to DRAIN.
REQ-014 DRAIN: in_ready=0; drain_cnt counts DRAIN_CYC cycles; then the FSM goes to DONE.
REQ-015 DONE: done=1 for exactly one cycle; the FSM then goes to IDLE.
REQ-016 Skew: an element a_in[i] accepted at cycle t SHALL appear on A_west[i] at cycle t+1+i; b_in[j] SHALL appear on B_north[j] at cycle t+1+j (a per-lane register chain of depth lane+1).
REQ-017 Every cycle without an accepted beat (stall, IDLE, DRAIN, DONE) SHALL inject zero into lane entry, so bubbles propagate as zero wavefronts and alignment is preserved.
REQ-018 Data SHALL pass unmodified with no arithmetic; width is DW throughout.
REQ-019 start while busy=1 SHALL be ignored; in_valid outside FEED SHALL be ignored.
REQ-020 k_len=0xFFFF SHALL feed 65535 beats; the counters are 16 bits and SHALL NOT wrap before completion.
REQ-021 A start in the same cycle as done SHALL be ignored; the FSM returns to IDLE first.

Reset
REQ-022 With rst=1 at a clock edge the FSM SHALL go to IDLE, counters SHALL clear to 0, and all skew registers SHALL clear to 0.
REQ-023 Reset outputs SHALL be: in_ready=0, busy=0, done=0, A_west=0, B_north=0.
REQ-024 Reset mid-FEED or mid-DRAIN SHALL abort the tile without a done pulse; the next cycle behaves as IDLE.

Configuration
REQ-025 Macro SYSTOLIC_FEEDER_STALL_CNT_EN SHALL control the stall counter.
REQ-026 When SYSTOLIC_FEEDER_STALL_CNT_EN is defined, output stall_cnt [31:0] SHALL count FEED cycles with in_valid=0; it clears on accepted start and on rst, saturates at 0xFFFFFFFF, and holds after DONE.
REQ-027 When SYSTOLIC_FEEDER_STALL_CNT_EN is undefined, the stall_cnt port and its logic SHALL be absent.

Verification (N=4, DW=16, DRAIN_CYC=10)
REQ-028 Basic: reset, start k_len=3, beats a_in=b_in={1,2,3,4}, {5,6,7,8}, {9,10,11,12} back-to-back from cycle 1 -> A_west[0]=1,5,9 at cycles 2,3,4; A_west[3]=4,8,12 at cycles 5,6,7; done pulses once 10 cycles after DRAIN entry.
REQ-029 Stall: same as REQ-028 with in_valid low for one cycle between beats 1 and 2 -> zero on all lanes in the bubble slot, each lane's relative skew unchanged.
REQ-030 k_len=0: start -> no in_ready, DRAIN 10 cycles, done; all outputs stay 0.
REQ-031 Reset mid-FEED: assert rst after beat 2 -> next cycle busy=0, in_ready=0, all outputs 0; no done.
REQ-032 Ignored start: pulse start again during FEED with k_len=7 -> the original k_len=3 is honoured; a start coincident with done is ignored.
REQ-033 With SYSTOLIC_FEEDER_STALL_CNT_EN defined, run REQ-029 -> stall_cnt=1 at done.
